// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per clock, K constants fetched from an external ROM.
// A 16-word sliding window supplies the message schedule W.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic         rom_rd,
    output logic [5:0]   rom_addr,
    input  logic [31:0]  rom_k
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StFinal} state_e;

    state_e        state_q, state_d;
    logic [5:0]    t_q, t_d;
    logic [31:0]   w_q [16];
    logic [31:0]   v_q [8];
    logic          init_q;
    logic          done_q;
    logic [255:0]  digest_q;
    logic [255:0]  hsel;
    logic [31:0]   t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // digest is frozen until the FINAL edge, so it still holds the pre-block chaining value
    assign hsel = init_q ? IV : digest_q;

    always_comb begin
        t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
             + rom_k + w_q[0];
        t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        rom_rd   = 1'b0;
        rom_addr = 6'd0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                rom_rd   = 1'b1;
                rom_addr = 6'd0;
                t_d      = 6'd0;
                state_d  = StRound;
            end
            StRound: begin
                if (t_q != 6'd63) begin
                    rom_rd   = 1'b1;
                    rom_addr = t_q + 6'd1;
                    t_d      = t_q + 6'd1;
                end else begin
                    t_d     = 6'd0;
                    state_d = StFinal;
                end
            end
            StFinal: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign digest = digest_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            digest_q <= IV;
            init_q   <= 1'b1;
        end else begin
            done_q <= (state_q == StFinal);
            if (state_q == StIdle && start) begin
                init_q <= init;
            end
            if (state_q == StFinal) begin
                for (int i = 0; i < 8; i++) begin
                    digest_q[255-32*i -: 32] <= hsel[255-32*i -: 32] + v_q[i];
                end
            end
        end
    end

    // Working variables and schedule window need no reset: always loaded on acceptance
    always_ff @(posedge clk) begin
        if (state_q == StIdle && start && !rst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= block_in[511-32*i -: 32];
            end
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= init ? IV[255-32*i -: 32] : digest_q[255-32*i -: 32];
            end
        end else if (state_q == StRound) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_new;
            v_q[0] <= t1 + t2;
            v_q[1] <= v_q[0];
            v_q[2] <= v_q[1];
            v_q[3] <= v_q[2];
            v_q[4] <= v_q[3] + t1;
            v_q[5] <= v_q[4];
            v_q[6] <= v_q[5];
            v_q[7] <= v_q[6];
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: known-answer vectors, ROM port protocol, control corner cases,
// and randomized chained blocks checked against a straightforward SHA-256 reference.
module tb_sha256_compress;

    logic         clk = 1'b0;
    logic         rst, start, init;
    logic [511:0] block_in;
    logic         busy, done;
    logic [255:0] digest;
    logic         rom_rd;
    logic [5:0]   rom_addr;
    logic [31:0]  rom_k = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int stray_rom = 0;
    logic [255:0] model_h;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] BLK_TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_compress dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init     (init),
        .block_in (block_in),
        .busy     (busy),
        .done     (done),
        .digest   (digest),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_k    (rom_k)
    );

    always #5 clk = ~clk;

    // K ROM with one cycle of read latency
    always @(posedge clk) if (rom_rd) rom_k <= k_tab[rom_addr];

    always @(negedge clk) begin
        if (!busy && (rom_rd || rom_addr != 6'd0)) stray_rom++;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
                 + k_tab[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Starts a block at the current negedge and runs until done (bounded); optionally
    // pulses a second start at cycle poke_at. Returns latency in edges after acceptance.
    task automatic run_block(input logic [511:0] blk, input logic ini, input int poke_at,
                             output int lat, output int rom_cnt, output bit rom_ok);
        start = 1'b1; init = ini; block_in = blk;
        lat = -1; rom_cnt = 0; rom_ok = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1 || c == poke_at + 1) begin
                start = 1'b0; init = 1'($urandom); block_in = rand_block();
            end
            if (c == poke_at) begin
                start = 1'b1; init = 1'($urandom); block_in = rand_block();
            end
            if (rom_rd) begin
                if (rom_cnt > 63 || rom_addr != 6'(rom_cnt)) rom_ok = 1'b0;
                rom_cnt++;
            end
            if (done) begin
                lat = c - 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; init = 1'b0; block_in = BLK_ABC;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
        end
        vectors++;
        if (rom_rd !== 1'b0 || rom_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_rom: rd=%b addr=%0d, want 0 0", rom_rd, rom_addr);
        end
        vectors++;
        if (digest !== IV) begin
            miscompares++;
            $display("FAIL reset_digest: got %h want %h", digest, IV);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        model_h = IV;
    endtask

    task automatic test_abc();
        int lat, rc;
        bit rok;
        run_block(BLK_ABC, 1'b1, 0, lat, rc, rok);
        vectors++;
        if (lat != 66) begin
            miscompares++;
            $display("FAIL abc_latency: got %0d edges want 66", lat);
        end
        vectors++;
        if (digest !== DIG_ABC) begin
            miscompares++;
            $display("FAIL abc_digest: got %h want %h", digest, DIG_ABC);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_done_pulse: done=%b busy=%b after pulse, want 0 0", done, busy);
        end
        model_h = DIG_ABC;
    endtask

    task automatic test_empty();
        int lat, rc;
        bit rok;
        run_block(BLK_EMPTY, 1'b1, 0, lat, rc, rok);
        vectors++;
        if (digest !== DIG_EMPTY || lat != 66) begin
            miscompares++;
            $display("FAIL empty_digest: got %h lat %0d want %h lat 66", digest, lat, DIG_EMPTY);
        end
        model_h = DIG_EMPTY;
    endtask

    task automatic test_two_block();
        int lat, rc;
        bit rok;
        logic [255:0] mid;
        mid = sha_ref(IV, BLK_TWO1);
        run_block(BLK_TWO1, 1'b1, 0, lat, rc, rok);
        vectors++;
        if (digest !== mid) begin
            miscompares++;
            $display("FAIL two_block_first: got %h want %h", digest, mid);
        end
        run_block(BLK_TWO2, 1'b0, 0, lat, rc, rok);
        vectors++;
        if (digest !== DIG_TWO || lat != 66) begin
            miscompares++;
            $display("FAIL two_block_final: got %h lat %0d want %h lat 66", digest, lat, DIG_TWO);
        end
        model_h = DIG_TWO;
    endtask

    task automatic test_rom_port();
        int lat, rc;
        bit rok;
        stray_rom = 0;
        repeat (2) @(negedge clk);
        run_block(BLK_ABC, 1'b1, 0, lat, rc, rok);
        repeat (3) @(negedge clk);
        vectors++;
        if (rc != 64 || !rok) begin
            miscompares++;
            $display("FAIL rom_sequence: %0d reads in_order=%0d, want 64 reads in order", rc, rok);
        end
        vectors++;
        if (stray_rom != 0) begin
            miscompares++;
            $display("FAIL rom_idle: %0d idle cycles with rom activity, want 0", stray_rom);
        end
        model_h = DIG_ABC;
    endtask

    task automatic test_ignore_start();
        int lat, rc, extra;
        bit rok;
        run_block(BLK_ABC, 1'b1, 12, lat, rc, rok);
        vectors++;
        if (digest !== DIG_ABC || lat != 66) begin
            miscompares++;
            $display("FAIL ignore_digest: got %h lat %0d want %h lat 66", digest, lat, DIG_ABC);
        end
        extra = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignore_queued: %0d busy/done cycles after block, want 0", extra);
        end
        model_h = DIG_ABC;
    endtask

    task automatic test_reset_mid();
        int lat, rc, stray;
        bit rok;
        stray = 0;
        start = 1'b1; init = 1'b1; block_in = BLK_EMPTY;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) stray++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || digest !== IV) begin
            miscompares++;
            $display("FAIL midreset_state: busy=%b done=%b digest=%h want 0 0 %h",
                     busy, done, digest, IV);
        end
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL midreset_stray: %0d stray busy/done cycles, want 0", stray);
        end
        run_block(BLK_ABC, 1'b0, 0, lat, rc, rok);
        vectors++;
        if (digest !== DIG_ABC) begin
            miscompares++;
            $display("FAIL midreset_abc: got %h want %h", digest, DIG_ABC);
        end
        model_h = DIG_ABC;
    endtask

    task automatic test_random();
        int lat, rc;
        bit rok;
        logic ini;
        logic [511:0] blk;
        logic [255:0] exp;
        for (int n = 0; n < 8; n++) begin
            ini = 1'($urandom_range(0, 1));
            blk = rand_block();
            exp = sha_ref(ini ? IV : model_h, blk);
            run_block(blk, ini, 0, lat, rc, rok);
            vectors++;
            if (digest !== exp || lat != 66) begin
                miscompares++;
                $display("FAIL random_%0d: init=%b got %h lat %0d want %h lat 66",
                         n, ini, digest, lat, exp);
            end
            model_h = exp;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; init = 1'b0; block_in = '0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_rom_port();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 SHALL have no parameters; all widths are fixed by FIPS 180-4 SHA-256.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to compress block_in; sampled only in IDLE.
REQ-005 init  input  1  sampled with start: 1 = chain from IV, 0 = chain from current digest.
REQ-006 block_in  input  512  padded message block, word 0 = block_in[511:480] (big-endian).
REQ-007 busy  output  1  high from the cycle after start acceptance until done is asserted.
REQ-008 done  output  1  one-cycle pulse; digest is valid while done is high.
REQ-009 digest  output  256  chaining value H0..H7, H0 = digest[255:224].
REQ-010 rom_rd  output  1  read strobe to the K-constant ROM.
REQ-011 rom_addr  output  6  K index to the ROM.
REQ-012 rom_k  input  32  ROM data, valid one cycle after the rom_rd/rom_addr edge.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, with a 6-bit round counter t.
REQ-014 IDLE + start=1 at edge E0: SHALL latch block_in into a 16x32 W shift register.
REQ-015 At E0 SHALL load a..h from IV (init=1) or from digest (init=0), then go to LOAD.
REQ-016 LOAD SHALL last one cycle with rom_rd=1, rom_addr=0, then go to ROUND with t=0.
REQ-017 ROUND cycle t SHALL drive rom_rd=1, rom_addr=t+1 for t<63, and rom_rd=0 at t=63.
REQ-018 Outside LOAD/ROUND, rom_rd SHALL be 0 and rom_addr SHALL be 0.
REQ-019 rom_k in ROUND cycle t SHALL be used as K[t]; no other K source SHALL exist.
REQ-020 Each ROUND edge SHALL perform one standard SHA-256 round with Wt = W[0].
REQ-021 On that edge W SHALL shift down by one word, shifting in sig1(W[14]) + W[9] + sig0(W[1]) + W[0] (mod 2^32).
REQ-022 All additions SHALL be modulo 2^32; rotations/shifts per FIPS 180-4 (Sigma0 2/13/22, Sigma1 6/11/25, sig0 7/18/>>3, sig1 17/19/>>10).
REQ-023 After the t=63 round (edge E65) the FSM SHALL go to FINAL.
REQ-024 FINAL edge (E66) SHALL set digest[i] <= Hsel[i] + var[i], where Hsel is the IV or pre-block digest selected at E0 and var = a..h.
REQ-025 The FINAL edge SHALL also set done=1 for exactly one cycle and return the FSM to IDLE.
REQ-026 Latency: done SHALL be high in the cycle after E66, i.e. 66 clock edges after the edge that accepts start.
REQ-027 busy SHALL be 1 in LOAD, ROUND and FINAL, and 0 in IDLE.
REQ-028 start while busy=1 SHALL be ignored (not queued); block_in and init SHALL be don't-care except at acceptance.
REQ-029 start in the cycle done=1 SHALL be accepted, since the FSM is in IDLE; with init=0 it chains from the new digest.
REQ-030 digest SHALL hold its value in all states except at the FINAL edge and at reset.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, t=0, busy=0, done=0, rom_rd=0, rom_addr=0, and digest=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
REQ-032 rst SHALL take priority over start.
REQ-033 rst mid-operation SHALL abort the block with no done pulse; init=0 after reset SHALL be equivalent to init=1.

Verification
REQ-034 "abc" padded block (61626380, zeros, last word 00000018), init=1 -> done after 66 edges, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-035 Empty-message block (80000000, then zeros), init=1 -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-036 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block1 init=1, then block2 init=0 started in the done cycle -> digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-037 ROM port check with a behavioural 1-cycle-latency ROM model -> rom_addr = 0..63 on consecutive rom_rd cycles, each exactly once, and no rom_rd outside LOAD/ROUND.
REQ-038 Second start pulsed at round t=10 -> ignored; exactly one done pulse; "abc" digest unchanged.
REQ-039 rst at round t=30, then "abc" with init=0 -> busy/done drop at the reset edge, no stray done, digest = IV after reset, final digest matches REQ-034.
